// File: rtl/pulse_burst_ctrl.sv
// Programmable pulse-train sequencer: emits burst_len one-cycle pulses spaced
// period cycles apart (or runs until abort when burst_len is zero).
module pulse_burst_ctrl #(
  parameter int PER_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PER_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [PER_W-1:0]   per_q;
  logic [BURST_W-1:0] len_q;
  logic [PER_W-1:0]   cyc;
  logic               accept;
  logic               pulse_due;
  logic               last_pulse;

  assign accept     = (state == IDLE) && start && !abort;
  assign pulse_due  = (state == RUN) && (cyc == per_q - PER_W'(1));
  // Continuous mode (len_q == 0) must never match, even when pulse_cnt wraps.
  assign last_pulse = pulse_due && (len_q != '0) &&
                      ((pulse_cnt + BURST_W'(1)) == len_q);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = RUN;
      end
      RUN: begin
        if (abort)           next_state = IDLE;
        else if (last_pulse) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Abort takes priority over a pulse that falls due on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q     <= '0;
      len_q     <= '0;
      cyc       <= '0;
      pulse_cnt <= '0;
      pulse     <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            per_q     <= (period == '0) ? PER_W'(1) : period;
            len_q     <= burst_len;
            cyc       <= '0;
            pulse_cnt <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            cyc <= '0;
          end else if (pulse_due) begin
            cyc       <= '0;
            pulse     <= 1'b1;
            pulse_cnt <= pulse_cnt + BURST_W'(1);
          end else begin
            cyc <= cyc + PER_W'(1);
          end
        end
        default: begin
          cyc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Directed self-checking bench for pulse_burst_ctrl, including a 4-bit
// burst counter instance to exercise pulse_cnt wrap-around.
module tb_pulse_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] burst_len = 8'd0;
  logic       pulse;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  logic       start4 = 1'b0;
  logic       pulse4;
  logic       busy4;
  logic       done4;
  logic [3:0] pulse_cnt4;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  pulse_burst_ctrl #(.PER_W(8), .BURST_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .period(period), .burst_len(burst_len),
    .pulse(pulse), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
  );

  pulse_burst_ctrl #(.PER_W(8), .BURST_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(1'b0),
    .period(8'd1), .burst_len(4'd0),
    .pulse(pulse4), .busy(busy4), .done(done4), .pulse_cnt(pulse_cnt4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Leaves the bench 1 time unit after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for exactly one edge (edge 0 of the burst).
  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] n);
    period    = p;
    burst_len = n;
    start     = 1'b1;
    stepCycle();
    start     = 1'b0;
  endtask

  initial begin
    #2;
    checkOutput("reset_pulse", 32'(pulse), 32'd0);
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_done",  32'(done),  32'd0);
    checkOutput("reset_cnt",   32'(pulse_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle();

    // P=4, N=3: pulses in cycles 4, 8, 12; done only in 12.
    applyStimulus(8'd4, 8'd3);
    checkOutput("p4_busy_c0", 32'(busy), 32'd1);
    for (int n = 1; n <= 14; n++) begin
      stepCycle();
      checkOutput("p4_pulse", 32'(pulse), 32'((n == 4) || (n == 8) || (n == 12)));
      checkOutput("p4_done",  32'(done),  32'(n == 12));
      checkOutput("p4_busy",  32'(busy),  32'(n <= 12));
    end
    checkOutput("p4_cnt", 32'(pulse_cnt), 32'd3);

    // P=0 behaves as P=1.
    applyStimulus(8'd0, 8'd2);
    for (int n = 1; n <= 3; n++) begin
      stepCycle();
      checkOutput("p0_pulse", 32'(pulse), 32'((n == 1) || (n == 2)));
      checkOutput("p0_done",  32'(done),  32'(n == 2));
    end
    checkOutput("p0_cnt", 32'(pulse_cnt), 32'd2);

    // P=10 continuous, then abort on the edge pulse 31 falls due.
    applyStimulus(8'd10, 8'd0);
    for (int n = 1; n <= 309; n++) begin
      stepCycle();
      checkOutput("p10_pulse", 32'(pulse), 32'((n % 10) == 0));
      checkOutput("p10_done",  32'(done),  32'd0);
    end
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("abort_pulse", 32'(pulse), 32'd0);
    checkOutput("abort_busy",  32'(busy),  32'd0);
    checkOutput("abort_done",  32'(done),  32'd0);
    checkOutput("abort_cnt",   32'(pulse_cnt), 32'd30);
    stepCycle();
    checkOutput("abort_idle_cnt", 32'(pulse_cnt), 32'd30);

    // P=5, N=4: async reset while the second pulse is high.
    applyStimulus(8'd5, 8'd4);
    for (int n = 1; n <= 10; n++) stepCycle();
    checkOutput("rst_pre_pulse", 32'(pulse), 32'd1);
    checkOutput("rst_pre_cnt",   32'(pulse_cnt), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_pulse", 32'(pulse), 32'd0);
    checkOutput("rst_mid_busy",  32'(busy),  32'd0);
    checkOutput("rst_mid_done",  32'(done),  32'd0);
    checkOutput("rst_mid_cnt",   32'(pulse_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'd5, 8'd4);
    for (int n = 1; n <= 5; n++) begin
      stepCycle();
      checkOutput("fresh_pulse", 32'(pulse), 32'(n == 5));
    end
    checkOutput("fresh_cnt", 32'(pulse_cnt), 32'd1);
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("fresh_abort_busy", 32'(busy), 32'd0);

    // P=3, N=2: second start and period change mid-burst are ignored.
    applyStimulus(8'd3, 8'd2);
    for (int n = 1; n <= 8; n++) begin
      if (n == 1) begin
        start  = 1'b1;
        period = 8'd7;
      end
      stepCycle();
      start = 1'b0;
      checkOutput("busy_pulse", 32'(pulse), 32'((n == 3) || (n == 6)));
      checkOutput("busy_done",  32'(done),  32'(n == 6));
    end
    checkOutput("busy_cnt",  32'(pulse_cnt), 32'd2);
    checkOutput("busy_idle", 32'(busy), 32'd0);

    // start and abort together in IDLE: abort wins.
    period = 8'd2;
    burst_len = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startabort_busy", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("startabort_busy2", 32'(busy), 32'd0);
    checkOutput("startabort_cnt", 32'(pulse_cnt), 32'd2);

    // 4-bit counter, P=1 continuous: wraps 15 -> 0, reads 4 at cycle 20.
    start4 = 1'b1;
    stepCycle();
    start4 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      stepCycle();
      checkOutput("wrap_pulse", 32'(pulse4), 32'd1);
      if (n == 15) checkOutput("wrap_cnt15", 32'(pulse_cnt4), 32'd15);
      if (n == 16) checkOutput("wrap_cnt16", 32'(pulse_cnt4), 32'd0);
    end
    checkOutput("wrap_cnt20", 32'(pulse_cnt4), 32'd4);
    checkOutput("wrap_done",  32'(done4), 32'd0);
    checkOutput("wrap_busy",  32'(busy4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
